vga_pixel_scanout: RTL and testbench
====================================

// Module: vga_pixel_scanout
// PURPOSE
//  Pixel-clock-domain consumer of vga_async_fifo read side: generates VGA raster timing (HSYNC/VSYNC/DE),
//  pops one RGB565 word per active pixel from the FIFO (first-word-fall-through), drives registered RGB pins.
//  Sits between the FIFO read port and the DAC/pins; reports underflow and frame boundaries to the frame fetcher.
// PARAMETERS
//  N         16   FIFO data width (RGB565: [15:11]=R, [10:5]=G, [4:0]=B)
//  H_ACTIVE  640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48  (H_TOTAL = sum = 800)
//  V_ACTIVE  480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33  (V_TOTAL = sum = 525)
//  H_POL     0    HSYNC active level;  V_POL 0  VSYNC active level
//  CNT_W     11   width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  iCLOCK            in   1   pixel clock (= FIFO iRD_CLOCK)
//  iRESET_SYNC       in   1   synchronous reset, active-high
//  iDISP_ENABLE      in   1   request scanout; sampled only at frame boundary
//  iFIFO_EMPTY       in   1   FIFO oRD_EMPTY
//  iFIFO_DATA        in   N   FIFO oRD_DATA (valid whenever !iFIFO_EMPTY)
//  oFIFO_RD_EN       out  1   FIFO iRD_EN; combinational pop strobe
//  oVGA_HSYNC/VSYNC  out  1   registered sync outputs
//  oVGA_DE           out  1   registered data enable
//  oVGA_R/G/B        out  5/6/5 registered colour
//  oFRAME_START      out  1   1-cycle pulse, h==0 && v==0 while RUN
//  oUNDERFLOW        out  1   sticky: active pixel needed while FIFO empty
//  iUNDERFLOW_CLEAR  in   1   clears oUNDERFLOW (set wins if same cycle)
// BEHAVIOUR
//  Reset: h=v=0, state IDLE, HSYNC=~H_POL, VSYNC=~V_POL, DE=0, RGB=0, RD_EN=0, FRAME_START=0, UNDERFLOW=0.
//  Counters free-run in every state: h 0..H_TOTAL-1 wraps to 0 and increments v; v wraps at V_TOTAL-1.
//  active = (h<H_ACTIVE)&&(v<V_ACTIVE); hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise on v.
//  Pins registered: value for counter (h,v) appears 1 cycle later; syncs and DE share that 1-cycle latency.
//  FSM: IDLE  -> WAIT when iDISP_ENABLE=1.
//       WAIT  -> RUN at last cycle of frame (h=H_TOTAL-1, v=V_TOTAL-1); to IDLE if iDISP_ENABLE drops first.
//       RUN   -> IDLE at last cycle of frame if iDISP_ENABLE=0 (frame always completes; no mid-frame stop).
//  IDLE/WAIT: syncs keep running, DE=0, RGB=0, RD_EN=0 (monitor stays locked, FIFO untouched).
//  RUN, active, !empty: RD_EN=1, RGB<=iFIFO_DATA fields, DE<=1.
//  RUN, active, empty : RD_EN=0, RGB<=0, DE<=1, UNDERFLOW<=1; pixel dropped, no catch-up pop later.
//  RUN, blanking      : RD_EN=0, RGB<=0, DE<=0.
//  Exactly H_ACTIVE*V_ACTIVE pops per underflow-free frame; RD_EN never asserted while iFIFO_EMPTY=1.
//  iRESET_SYNC mid-frame: all of the above reset values next cycle, counters restart at (0,0), FSM IDLE.
// STRUCTURE
//  Shared package vga_pkg: scanout_state_t enum {IDLE, WAIT, RUN}; default 640x480@60 timing localparams.
//  Sub-module vga_raster_counter: h/v counters + active/hs/vs/last_of_frame decode (pure timing, no FIFO).
//  Top holds FSM, pop logic, output registers, underflow flag.
// TESTING  (small timing: H 8/2/3/3 -> H_TOTAL 16, V 4/1/2/1 -> V_TOTAL 8, POL=0)
//  Reset, iDISP_ENABLE=0 for 300 cycles -> HSYNC low h=10..12, VSYNC low v=5..6, DE=0, RD_EN never 1.
//  Enable with FIFO always non-empty, data=pixel index -> RUN after first wrap; 32 pops/frame; RGB matches 1 cycle later.
//  FIFO empty on pixel (h=3,v=1) only -> that pixel RGB=0 with DE=1, UNDERFLOW=1, next pixel takes next word.
//  UNDERFLOW_CLEAR and new underflow same cycle -> flag stays 1; clear alone -> 0 next cycle.
//  Drop iDISP_ENABLE at (h=5,v=2) -> frame finishes (32 pops total), IDLE from next frame, FRAME_START stops.
//  iRESET_SYNC at (h=6,v=1) in RUN -> next cycle all outputs reset values, counters (0,0), no RD_EN until re-armed.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA scanout types and default 640x480@60 raster timing.
package vga_pkg;

    localparam int unsigned N_DEF        = 16;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned CNT_W_DEF    = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } scanout_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/vga_raster_counter.sv
// Free-running h/v raster counters with active, sync and end-of-frame decode.
module vga_raster_counter #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic             iCLOCK,
    input  logic             iRESET_SYNC,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             active_c,
    output logic             hs_c,
    output logic             vs_c,
    output logic             last_of_frame_c
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic h_last_c;
    logic v_last_c;

    assign h_last_c = (h_count == CNT_W'(H_TOTAL - 1));
    assign v_last_c = (v_count == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last_c) begin
            h_count <= '0;
            v_count <= v_last_c ? '0 : v_count + CNT_W'(1);
        end else begin
            h_count <= h_count + CNT_W'(1);
        end
    end

    assign active_c        = (h_count < CNT_W'(H_ACTIVE)) && (v_count < CNT_W'(V_ACTIVE));
    assign hs_c            = (h_count >= CNT_W'(HS_START)) && (h_count < CNT_W'(HS_END));
    assign vs_c            = (v_count >= CNT_W'(VS_START)) && (v_count < CNT_W'(VS_END));
    assign last_of_frame_c = h_last_c && v_last_c;

endmodule

// File: rtl/vga_pixel_scanout.sv
// Pixel-clock VGA scanout: raster timing, FWFT FIFO pops per active pixel, registered pins.
module vga_pixel_scanout
    import vga_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic         iDISP_ENABLE,
    input  logic         iFIFO_EMPTY,
    input  logic [N-1:0] iFIFO_DATA,
    output logic         oFIFO_RD_EN,
    output logic         oVGA_HSYNC,
    output logic         oVGA_VSYNC,
    output logic         oVGA_DE,
    output logic [4:0]   oVGA_R,
    output logic [5:0]   oVGA_G,
    output logic [4:0]   oVGA_B,
    output logic         oFRAME_START,
    output logic         oUNDERFLOW,
    input  logic         iUNDERFLOW_CLEAR
);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             active_c;
    logic             hs_c;
    logic             vs_c;
    logic             last_of_frame_c;

    scanout_state_t   state;
    scanout_state_t   state_nxt;
    logic             pixel_c;
    logic             pop_c;
    logic             underflow_set_c;
    logic             frame_start_c;
    rgb565_t          fifo_pix_c;
    rgb565_t          pix_q;

    vga_raster_counter #(
        .CNT_W    (CNT_W),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .iCLOCK          (iCLOCK),
        .iRESET_SYNC     (iRESET_SYNC),
        .h_count         (h_count),
        .v_count         (v_count),
        .active_c        (active_c),
        .hs_c            (hs_c),
        .vs_c            (vs_c),
        .last_of_frame_c (last_of_frame_c)
    );

    assign fifo_pix_c = rgb565_t'(iFIFO_DATA[15:0]);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode changes only at the last cycle of a frame, so a frame is never cut short.
    always_comb begin
        state_nxt       = state;
        pixel_c         = 1'b0;
        pop_c           = 1'b0;
        underflow_set_c = 1'b0;
        frame_start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (iDISP_ENABLE) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!iDISP_ENABLE) begin
                    state_nxt = IDLE;
                end else if (last_of_frame_c) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pixel_c         = active_c;
                pop_c           = active_c && !iFIFO_EMPTY && !iRESET_SYNC;
                underflow_set_c = active_c && iFIFO_EMPTY;
                frame_start_c   = (h_count == '0) && (v_count == '0);
                if (last_of_frame_c && !iDISP_ENABLE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oFIFO_RD_EN = pop_c;

    // Pin registers: everything derived from (h,v) shows up one cycle later, aligned.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oVGA_HSYNC   <= ~H_POL;
            oVGA_VSYNC   <= ~V_POL;
            oVGA_DE      <= 1'b0;
            pix_q        <= '0;
            oFRAME_START <= 1'b0;
            oUNDERFLOW   <= 1'b0;
        end else begin
            oVGA_HSYNC   <= hs_c ? H_POL : ~H_POL;
            oVGA_VSYNC   <= vs_c ? V_POL : ~V_POL;
            oVGA_DE      <= pixel_c;
            pix_q        <= pop_c ? fifo_pix_c : '0;
            oFRAME_START <= frame_start_c;
            if (underflow_set_c) begin
                oUNDERFLOW <= 1'b1;
            end else if (iUNDERFLOW_CLEAR) begin
                oUNDERFLOW <= 1'b0;
            end
        end
    end

    assign oVGA_R = pix_q.r;
    assign oVGA_G = pix_q.g;
    assign oVGA_B = pix_q.b;

endmodule

// File: tb/tb_vga_pixel_scanout.sv
// Scoreboard bench for vga_pixel_scanout on a 16x8 raster.
module tb_vga_pixel_scanout;

    localparam int unsigned H_ACT = 8;
    localparam int unsigned V_ACT = 4;
    localparam int          H_TOT = 16;
    localparam int          V_TOT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_en;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        rd_en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        frame_start;
    logic        underflow;
    logic        uf_clr;

    always #5 clk = ~clk;

    vga_pixel_scanout #(
        .N        (16),
        .H_ACTIVE (H_ACT),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (V_ACT),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .H_POL    (1'b0),
        .V_POL    (1'b0),
        .CNT_W    (11)
    ) dut (
        .iCLOCK           (clk),
        .iRESET_SYNC      (rst),
        .iDISP_ENABLE     (disp_en),
        .iFIFO_EMPTY      (fifo_empty),
        .iFIFO_DATA       (fifo_data),
        .oFIFO_RD_EN      (rd_en),
        .oVGA_HSYNC       (hsync),
        .oVGA_VSYNC       (vsync),
        .oVGA_DE          (de),
        .oVGA_R           (r),
        .oVGA_G           (g),
        .oVGA_B           (b),
        .oFRAME_START     (frame_start),
        .oUNDERFLOW       (underflow),
        .iUNDERFLOW_CLEAR (uf_clr)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
        logic        fs;
        logic        uf;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int m_h, m_v, m_st;
    bit m_uf;
    int head;
    int dut_pops;
    bit d_rst, d_en, d_empty, d_clr;

    function automatic logic [15:0] word_of(int idx);
        return 16'(idx * 40503 + 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("de", 32'(de), 32'(e.de));
        check("rgb", 32'({r, g, b}), 32'(e.rgb));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("underflow", 32'(underflow), 32'(e.uf));
    endtask

    // One pixel clock: check last cycle's registered outputs, drive, predict, advance.
    task automatic tick();
        exp_t e;
        bit act, hs, vs, last, run, pop;
        compare_outputs();
        rst        = d_rst;
        disp_en    = d_en;
        fifo_empty = d_empty;
        uf_clr     = d_clr;
        fifo_data  = word_of(head);
        #1;
        e = '0;
        pop = 1'b0;
        if (d_rst) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            m_h = 0; m_v = 0; m_st = 0; m_uf = 1'b0;
        end else begin
            act  = (m_h < H_ACT) && (m_v < V_ACT);
            hs   = (m_h >= 10) && (m_h < 13);
            vs   = (m_v >= 5) && (m_v < 7);
            last = (m_h == H_TOT - 1) && (m_v == V_TOT - 1);
            run  = (m_st == 2);
            pop  = run && act && !d_empty;
            e.hs  = !hs;
            e.vs  = !vs;
            e.de  = run && act;
            e.rgb = pop ? fifo_data : 16'h0;
            e.fs  = run && (m_h == 0) && (m_v == 0);
            if (run && act && d_empty) m_uf = 1'b1;
            else if (d_clr)            m_uf = 1'b0;
            e.uf = m_uf;
            case (m_st)
                0: if (d_en) m_st = 1;
                1: if (!d_en) m_st = 0; else if (last) m_st = 2;
                default: if (last && !d_en) m_st = 0;
            endcase
            if (m_h == H_TOT - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
        end
        check("rd_en", 32'(rd_en), 32'(pop));
        if (rd_en) dut_pops++;
        if (rd_en && !fifo_empty) head++;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int h, input int v);
        int k = 0;
        while (!(m_h == h && m_v == v) && k < 256) begin
            tick();
            k++;
        end
        check("reach_pos", 32'(k < 256), 32'(1));
    endtask

    task automatic wait_run();
        int k = 0;
        while (m_st != 2 && k < 400) begin
            tick();
            k++;
        end
        check("reach_run", 32'(k < 400), 32'(1));
    endtask

    initial begin
        d_rst = 1'b1; d_en = 1'b0; d_empty = 1'b0; d_clr = 1'b0;
        m_h = 0; m_v = 0; m_st = 0; m_uf = 1'b0;
        head = 0; dut_pops = 0;

        run_n(2);
        d_rst = 1'b0;
        run_n(300);
        check("idle_pops", 32'(dut_pops), 32'(0));

        d_en = 1'b1;
        wait_run();
        dut_pops = 0;
        run_n(H_TOT * V_TOT);
        check("pops_full_frame", 32'(dut_pops), 32'(32));

        run_to(3, 1);
        d_empty = 1'b1;
        tick();
        d_empty = 1'b0;
        run_n(3);
        check("uflow_sticky", 32'(underflow), 32'(1));

        run_to(10, 1);
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        check("uflow_clear", 32'(underflow), 32'(0));

        run_to(2, 2);
        d_empty = 1'b1;
        d_clr = 1'b1;
        tick();
        d_empty = 1'b0;
        d_clr = 1'b0;
        check("uflow_set_wins", 32'(underflow), 32'(1));
        run_to(12, 2);
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        check("uflow_clear2", 32'(underflow), 32'(0));

        run_to(0, 0);
        dut_pops = 0;
        run_to(5, 2);
        d_en = 1'b0;
        run_to(0, 0);
        check("pops_after_drop", 32'(dut_pops), 32'(32));
        dut_pops = 0;
        run_n(H_TOT * V_TOT);
        check("pops_idle_frame", 32'(dut_pops), 32'(0));

        d_en = 1'b1;
        wait_run();
        run_to(6, 1);
        d_rst = 1'b1;
        d_en = 1'b0;
        tick();
        d_rst = 1'b0;
        check("rst_hsync", 32'(hsync), 32'(1));
        check("rst_de", 32'(de), 32'(0));
        check("rst_rgb", 32'({r, g, b}), 32'(0));
        dut_pops = 0;
        run_n(64);
        check("pops_after_reset", 32'(dut_pops), 32'(0));

        d_en = 1'b1;
        wait_run();
        dut_pops = 0;
        run_n(H_TOT * V_TOT);
        check("pops_rearmed", 32'(dut_pops), 32'(32));
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
